tlb_probe_read: RTL and testbench

- Answers the read side of the TLB: the inverse of the TLBWI/TLBWR write path.
- Executes TLBP (associative probe on CP0 EntryHi) and TLBR (indexed read into EntryHi/EntryLo0/EntryLo1) as a multi-cycle operation.
- The probe scans the 16-entry array one entry per cycle and stalls the pipeline while busy.
- Results go back to CP0 through dedicated write ports in a single DONE cycle.

---
 rtl/tlb_probe_read_pkg.sv | 27 ++
 rtl/tlb_probe_read_if.sv | 31 +++
 rtl/tlb_entry_match.sv | 18 +
 rtl/tlb_probe_read.sv | 108 ++++++++++
 tb/tb_tlb_probe_read.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/tlb_probe_read_pkg.sv
// tlb_probe_read_pkg: shared constants, entry field positions and FSM states for the TLB read side.
//   Opcodes of the instructions served (TLBP, TLBR), entry layout
//   {EntryHi[95:64], EntryLo0[63:32], EntryLo1[31:0]}, Index P-bit.
package tlb_probe_read_pkg;
   localparam int TLB_ENTRIES = 16;
   localparam int IDX_W = $clog2(TLB_ENTRIES);
   localparam int ENTRY_W = 96;
   localparam logic [31:0] TLBP_OP = 32'h4200_0008;
   localparam logic [31:0] TLBR_OP = 32'h4200_0001;
   localparam int VPN2_HI = 95;
   localparam int VPN2_LO = 77;
   localparam int ASID_HI = 71;
   localparam int ASID_LO = 64;
   localparam int G0_BIT = 32;
   localparam int G1_BIT = 0;
   localparam int PFN0_HI = 57;
   localparam int PFN0_LO = 38;
   localparam int PFN1_HI = 25;
   localparam int PFN1_LO = 6;
   localparam int VPN2_W = VPN2_HI - VPN2_LO + 1;
   localparam int ASID_W = ASID_HI - ASID_LO + 1;
   localparam logic [31:0] INDEX_P = 32'h8000_0000;
   typedef enum logic [1:0] {IDLE, PROBE, READ, DONE} state_t;
   function automatic logic [31:0] index_word(input logic [IDX_W-1:0] i);
      return {{(32-IDX_W){1'b0}}, i};
   endfunction
endpackage

// File: rtl/tlb_probe_read_if.sv
// tlb_probe_read_if: CP0/pipeline handshake plus TLB array read port of the probe/read unit.
//   master: issue side (starts, flush, bypassed Index/EntryHi, array data)
//   slave : the probe/read unit (stall, done, CP0 write ports, array address)
interface tlb_probe_read_if;
   import tlb_probe_read_pkg::*;
   logic start_probe_i;
   logic start_read_i;
   logic flush_i;
   logic [31:0] index_i;
   logic [31:0] entryhi_i;
   logic [IDX_W-1:0] entry_idx_o;
   logic [ENTRY_W-1:0] entry_i;
   logic stall_req_o;
   logic done_o;
   logic index_we_o;
   logic [31:0] index_data_o;
   logic entry_we_o;
   logic [31:0] entryhi_data_o;
   logic [31:0] entrylo0_data_o;
   logic [31:0] entrylo1_data_o;
   modport master (
      output start_probe_i, start_read_i, flush_i, index_i, entryhi_i, entry_i,
      input  entry_idx_o, stall_req_o, done_o, index_we_o, index_data_o,
             entry_we_o, entryhi_data_o, entrylo0_data_o, entrylo1_data_o
   );
   modport slave (
      input  start_probe_i, start_read_i, flush_i, index_i, entryhi_i, entry_i,
      output entry_idx_o, stall_req_o, done_o, index_we_o, index_data_o,
             entry_we_o, entryhi_data_o, entrylo0_data_o, entrylo1_data_o
   );
endinterface

// File: rtl/tlb_entry_match.sv
// tlb_entry_match: combinational VPN2/ASID/global compare of one TLB entry.
//   vpn2, asid     : key being looked up
//   e_vpn2, e_asid : fields of the entry
//   g0, g1         : G bits of EntryLo0/EntryLo1; entry is global only if both set
//   hit            : entry matches the key
module tlb_entry_match
   import tlb_probe_read_pkg::*;
(
   input  logic [VPN2_W-1:0] vpn2,
   input  logic [ASID_W-1:0] asid,
   input  logic [VPN2_W-1:0] e_vpn2,
   input  logic [ASID_W-1:0] e_asid,
   input  logic              g0,
   input  logic              g1,
   output logic              hit
);
   assign hit = (e_vpn2 == vpn2) && ((e_asid == asid) || (g0 && g1));
endmodule

// File: rtl/tlb_probe_read.sv
// tlb_probe_read: TLBP (sequential associative probe) and TLBR (indexed read) back to CP0.
//   clk, rst (async, active-low)
//   bus.slave: start/flush inputs, bypassed Index/EntryHi, TLB array address/data,
//              stall request, one-cycle done with CP0 Index / Entry* write ports
module tlb_probe_read
   import tlb_probe_read_pkg::*;
(
   input logic clk,
   input logic rst,
   tlb_probe_read_if.slave bus
);
   state_t state;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [VPN2_W-1:0] vpn2;
   logic [ASID_W-1:0] asid;
   logic done_q;
   logic iwe_q;
   logic ewe_q;
   logic [31:0] index_q;
   logic [31:0] hi_q;
   logic [31:0] lo0_q;
   logic [31:0] lo1_q;
   logic hit;
   logic can_start;
   logic unused;
   assign unused = ^{bus.index_i[31:IDX_W], bus.entryhi_i[ASID_HI-ASID_LO+1 +: 32-VPN2_W-ASID_W]};
   tlb_entry_match u_match (
      .vpn2   (vpn2),
      .asid   (asid),
      .e_vpn2 (bus.entry_i[VPN2_HI:VPN2_LO]),
      .e_asid (bus.entry_i[ASID_HI:ASID_LO]),
      .g0     (bus.entry_i[G0_BIT]),
      .g1     (bus.entry_i[G1_BIT]),
      .hit    (hit)
   );
   // A start accepted in IDLE or DONE must stall the issuing instruction in the same cycle.
   assign can_start = (state == IDLE || state == DONE) && !bus.flush_i;
   assign bus.stall_req_o = (state == PROBE) || (state == READ) ||
                            (can_start && (bus.start_probe_i || bus.start_read_i));
   assign bus.entry_idx_o = (state == PROBE) ? cnt : idx;
   assign bus.done_o = done_q;
   // A flush landing on the DONE cycle must not let the results reach CP0.
   assign bus.index_we_o = iwe_q && !bus.flush_i;
   assign bus.entry_we_o = ewe_q && !bus.flush_i;
   assign bus.index_data_o = index_q;
   assign bus.entryhi_data_o = hi_q;
   assign bus.entrylo0_data_o = lo0_q;
   assign bus.entrylo1_data_o = lo1_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         vpn2 <= '0;
         asid <= '0;
         done_q <= 1'b0;
         iwe_q <= 1'b0;
         ewe_q <= 1'b0;
         index_q <= '0;
         hi_q <= '0;
         lo0_q <= '0;
         lo1_q <= '0;
      end else begin
         done_q <= 1'b0;
         iwe_q <= 1'b0;
         ewe_q <= 1'b0;
         if (bus.flush_i) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE, DONE: begin
                  if (bus.start_probe_i) begin
                     vpn2 <= bus.entryhi_i[31:32-VPN2_W];
                     asid <= bus.entryhi_i[ASID_W-1:0];
                     cnt <= '0;
                     state <= PROBE;
                  end else if (bus.start_read_i) begin
                     idx <= bus.index_i[IDX_W-1:0];
                     state <= READ;
                  end else begin
                     state <= IDLE;
                  end
               end
               // Scanning upward and stopping on the first hit makes the lowest index win.
               PROBE: begin
                  if (hit || cnt == IDX_W'(TLB_ENTRIES - 1)) begin
                     index_q <= hit ? index_word(cnt) : INDEX_P;
                     done_q <= 1'b1;
                     iwe_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               READ: begin
                  hi_q <= bus.entry_i[95:64];
                  lo0_q <= bus.entry_i[63:32];
                  lo1_q <= bus.entry_i[31:0];
                  done_q <= 1'b1;
                  ewe_q <= 1'b1;
                  state <= DONE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tlb_probe_read.sv
// tb_tlb_probe_read: table-driven and randomized checks of tlb_probe_read against a TLB array model.
module tb_tlb_probe_read;
   logic clk;
   logic rst;
   logic [95:0] tlb [16];
   int total;
   int bad;
   tlb_probe_read_if bus ();
   tlb_probe_read dut (.clk(clk), .rst(rst), .bus(bus.slave));
   assign bus.entry_i = tlb[bus.entry_idx_o];
   initial clk = 1'b0;
   always #5 clk = ~clk;
   typedef struct {
      bit rd;
      bit clr3;
      logic [31:0] eh;
      logic [31:0] ix;
      int lat;
      logic [31:0] e_idx;
      logic [31:0] e_hi;
      logic [31:0] e_lo0;
      logic [31:0] e_lo1;
   } vec_t;
   vec_t v [9];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask
   // Lowest index whose VPN2 matches and whose ASID matches or is global; -1 on a miss.
   function automatic int model_probe(input logic [31:0] eh);
      for (int i = 0; i < 16; i++)
         if (tlb[i][95:77] == eh[31:13] && (tlb[i][71:64] == eh[7:0] || (tlb[i][32] && tlb[i][0])))
            return i;
      return -1;
   endfunction
   task automatic background();
      for (int i = 0; i < 16; i++)
         tlb[i] = {19'(32'h7F000 + i), 5'd0, 8'hAA, 32'h1000_0000 + 32'(2 * i), 32'h2000_0000 + 32'(2 * i)};
      tlb[3] = {32'h5A5A_4012, 32'h1000_0000, 32'h2000_0000};
      tlb[5] = {32'h0040_2012, 32'h0000_0042, 32'h0000_0082};
      tlb[7] = {32'hABCD_E0FF, 32'h0123_4567, 32'h89AB_CDEF};
      tlb[9] = {32'h5A5A_4000, 32'h0000_0001, 32'h0000_0001};
   endtask
   // Called at a negedge; issues the op now and returns at the negedge of the done cycle.
   task automatic run_op(input bit dp, input bit dr, input logic [31:0] eh, input logic [31:0] ix,
                         input int lat, input bit probe,
                         input logic [31:0] e_idx, input logic [31:0] e_hi,
                         input logic [31:0] e_lo0, input logic [31:0] e_lo1);
      int n;
      int sbad;
      bus.entryhi_i = eh;
      bus.index_i = ix;
      bus.start_probe_i = dp;
      bus.start_read_i = dr;
      #1;
      chk("stall_at_issue", 32'(bus.stall_req_o), 1);
      @(negedge clk);
      bus.start_probe_i = 1'b0;
      bus.start_read_i = 1'b0;
      n = 1;
      sbad = 0;
      while (!bus.done_o && n < 40) begin
         if (!bus.stall_req_o) sbad++;
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(lat));
      chk("stall_busy", 32'(sbad), 0);
      if (bus.done_o) begin
         chk("stall_in_done", 32'(bus.stall_req_o), 0);
         chk("index_we", 32'(bus.index_we_o), 32'(probe));
         chk("entry_we", 32'(bus.entry_we_o), 32'(!probe));
         if (probe) begin
            chk("index_data", bus.index_data_o, e_idx);
         end else begin
            chk("entryhi_data", bus.entryhi_data_o, e_hi);
            chk("entrylo0_data", bus.entrylo0_data_o, e_lo0);
            chk("entrylo1_data", bus.entrylo1_data_o, e_lo1);
         end
      end
   endtask
   task automatic idle_after();
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done_o), 0);
      chk("we_cleared", 32'({bus.index_we_o, bus.entry_we_o}), 0);
   endtask
   initial begin
      logic [18:0] pool [4];
      logic [7:0] apool [4];
      int k;
      int seen;
      logic [31:0] eh;
      logic [31:0] ix;
      total = 0;
      bad = 0;
      rst = 1'b0;
      bus.start_probe_i = 1'b0;
      bus.start_read_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.index_i = '0;
      bus.entryhi_i = '0;
      background();
      v[0] = '{0, 0, 32'h0040_2012, 0, 7, 32'h5, 0, 0, 0};
      v[1] = '{0, 0, 32'h1234_6000, 0, 17, 32'h8000_0000, 0, 0, 0};
      v[2] = '{0, 0, 32'h5A5A_4012, 0, 5, 32'h3, 0, 0, 0};
      v[3] = '{1, 0, 0, 32'h7, 2, 0, 32'hABCD_E0FF, 32'h0123_4567, 32'h89AB_CDEF};
      v[4] = '{0, 1, 32'h5A5A_4012, 0, 11, 32'h9, 0, 0, 0};
      v[5] = '{0, 0, 32'hFE00_00AA, 0, 2, 32'h0, 0, 0, 0};
      v[6] = '{0, 0, 32'hFE01_E0AA, 0, 17, 32'hF, 0, 0, 0};
      v[7] = '{1, 0, 0, 32'hFFFF_FFF7, 2, 0, 32'hABCD_E0FF, 32'h0123_4567, 32'h89AB_CDEF};
      v[8] = '{1, 0, 0, 32'h0, 2, 0, 32'hFE00_00AA, 32'h1000_0000, 32'h2000_0000};
      repeat (2) @(negedge clk);
      chk("rst_stall", 32'(bus.stall_req_o), 0);
      chk("rst_done", 32'(bus.done_o), 0);
      chk("rst_we", 32'({bus.index_we_o, bus.entry_we_o}), 0);
      chk("rst_index_data", bus.index_data_o, 0);
      chk("rst_entryhi_data", bus.entryhi_data_o, 0);
      chk("rst_entry_idx", 32'(bus.entry_idx_o), 0);
      rst = 1'b1;
      @(negedge clk);
      run_op(1, 1, 32'h0040_2012, 32'h7, 7, 1, 32'h5, 0, 0, 0);
      chk("both_read_dropped", bus.entryhi_data_o, 0);
      idle_after();
      for (int i = 0; i < 9; i++) begin
         if (v[i].clr3) tlb[3] = '0;
         run_op(!v[i].rd, v[i].rd, v[i].eh, v[i].ix, v[i].lat, !v[i].rd,
                v[i].e_idx, v[i].e_hi, v[i].e_lo0, v[i].e_lo1);
         idle_after();
      end
      for (int i = 0; i < 4; i++) begin
         pool[i] = 19'($urandom);
         apool[i] = 8'($urandom);
      end
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 16; i++) begin
            tlb[i] = {$urandom, $urandom, $urandom};
            tlb[i][95:77] = pool[$urandom_range(0, 3)];
            tlb[i][71:64] = apool[$urandom_range(0, 3)];
         end
         if ($urandom_range(0, 1) == 1) begin
            eh = {pool[$urandom_range(0, 3)], 5'($urandom), apool[$urandom_range(0, 3)]};
            k = model_probe(eh);
            run_op(1, 0, eh, $urandom, (k < 0) ? 17 : 2 + k, 1,
                   (k < 0) ? 32'h8000_0000 : 32'(k), 0, 0, 0);
         end else begin
            ix = $urandom;
            run_op(0, 1, $urandom, ix, 2, 0, 0,
                   tlb[ix[3:0]][95:64], tlb[ix[3:0]][63:32], tlb[ix[3:0]][31:0]);
         end
         if ($urandom_range(0, 1) == 1) idle_after();
      end
      idle_after();
      background();
      bus.entryhi_i = 32'h1234_6000;
      bus.start_probe_i = 1'b1;
      @(negedge clk);
      bus.start_probe_i = 1'b0;
      k = 0;
      while (bus.entry_idx_o != 4'd4 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("flush_reached_cnt4", 32'(bus.entry_idx_o), 4);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      chk("flush_idle_stall", 32'(bus.stall_req_o), 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done_o || bus.index_we_o || bus.entry_we_o) seen++;
         @(negedge clk);
      end
      chk("flush_no_done", 32'(seen), 0);
      run_op(0, 1, 0, 32'h7, 2, 0, 0, 32'hABCD_E0FF, 32'h0123_4567, 32'h89AB_CDEF);
      idle_after();
      run_op(1, 0, 32'h0040_2012, 0, 7, 1, 32'h5, 0, 0, 0);
      idle_after();
      bus.entryhi_i = 32'h1234_6000;
      bus.start_probe_i = 1'b1;
      @(negedge clk);
      bus.start_probe_i = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_stall", 32'(bus.stall_req_o), 0);
      chk("arst_done", 32'(bus.done_o), 0);
      chk("arst_we", 32'({bus.index_we_o, bus.entry_we_o}), 0);
      chk("arst_index_data", bus.index_data_o, 0);
      chk("arst_entryhi_data", bus.entryhi_data_o, 0);
      chk("arst_entrylo1_data", bus.entrylo1_data_o, 0);
      chk("arst_entry_idx", 32'(bus.entry_idx_o), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("arst_stays_idle", 32'(bus.stall_req_o), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
